oled_spi_master: RTL and testbench
==================================

# oled_spi_master

Byte-level SPI transmitter between the OLED command/data sequencers (clear, init, character draw) and the SSD1306 panel pins. It accepts one byte per `spi_send`/`send_done` handshake and the matching D/C level. It shifts the byte out MSB-first in SPI mode 0 (CPOL=0, CPHA=0) at `clk / (2*CLK_DIV)`, with chip-select framing, and pulses `send_done` so the client sequencer can advance its state.

## Interface
- `CLK_DIV`, default 4: half-period of `oled_sclk` in `clk` cycles. Integer ≥1. The divider counter width is `$clog2(CLK_DIV+1)`.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `spi_send` input, 1 bit: byte request. Level-sensitive; the client holds it high until it sees `send_done`.
- `spi_data` input, 8 bits: byte to transmit. Sampled only at the accept edge.
- `dc_in` input, 1 bit: D/C level for this byte (0 = command, 1 = data). Sampled at the accept edge.
- `send_done` output, 1 bit: one-cycle pulse when the byte is complete.
- `busy` output, 1 bit: high whenever state ≠ IDLE.
- `oled_sclk` output, 1 bit: SPI clock, idles low.
- `oled_mosi` output, 1 bit: serial data.
- `oled_cs_n` output, 1 bit: chip select, active-low.
- `oled_dc` output, 1 bit: registered D/C to the panel.

## Operation
- All outputs are registered.
- Reset values: `send_done`=0, `busy`=0, `oled_sclk`=0, `oled_mosi`=0, `oled_cs_n`=1, `oled_dc`=0. State is IDLE and all counters are 0.
- States: IDLE, SETUP, SHIFT, HOLD, [GAP], DONE.
- IDLE: at a clk edge where `spi_send`=1 (the accept edge):
  - latch `spi_data` into an 8-bit shift register
  - set `oled_dc`←`dc_in`, `oled_mosi`←`spi_data[7]`, `oled_cs_n`←0
  - clear the divider and bit counters, then go to SETUP.
- SETUP: hold `oled_sclk`=0 for CLK_DIV cycles, then drive `oled_sclk`←1 and go to SHIFT.
- SHIFT: toggle `oled_sclk` each time the divider reaches CLK_DIV.
  - On each falling edge (1→0), shift left and present the next bit on `oled_mosi`, then increment the 3-bit bit counter.
  - The panel samples on rising edges, so each bit is stable for one full SCLK period around its rising edge.
  - At the 8th falling edge (bit counter wraps 7→0), go to HOLD. Do not shift; `oled_mosi` retains bit 0.
- HOLD: `oled_sclk`=0 and `oled_cs_n`=0 for CLK_DIV cycles, then go to DONE (or GAP when enabled).
- DONE: `send_done`=1 for exactly this one cycle.
  - `oled_cs_n`=1 and `busy`=1.
  - `spi_send` is ignored in this cycle.
  - Next state is IDLE.
- `oled_dc` changes only at accept edges. It holds its value across IDLE.
- `spi_send` falling mid-byte is ignored; the byte always completes.
- `spi_data` and `dc_in` changes after the accept edge have no effect.
- Reset asserted mid-byte: outputs go to their reset values immediately (asynchronously) and the partial byte is abandoned. No `send_done` is issued.

## Timing
- Let D = CLK_DIV and the accept edge be cycle 0.
- SETUP occupies cycles 1..D.
- SHIFT occupies cycles D+1..16D: 8 high phases and 7 low phases of D cycles each.
  - Rising edges of `oled_sclk` occur at the start of cycles D+1, 3D+1, …, 15D+1.
- HOLD occupies cycles 16D+1..17D.
- DONE (`send_done` high) is cycle 17D+1, or 18D+1 with GAP.
- IDLE is re-entered at cycle 17D+2. A `spi_send` still high there starts the next byte at that edge.
- Sustained throughput: one byte per 17D+2 cycles (18D+2 with GAP).
- Clients that advance state on the `send_done` edge see their next request accepted one cycle later. No byte is ever sent twice.

## Configuration
- `OLED_SPI_CS_GAP_EN` defined:
  - Adds state GAP between HOLD and DONE.
  - `oled_cs_n`=1 and `oled_sclk`=0 for D cycles before `send_done`.
  - This guarantees the panel's minimum CS-high time between bytes.
- Not defined:
  - The GAP state and its logic are absent; HOLD goes directly to DONE.
  - `oled_cs_n` is high only in DONE and IDLE.

## Test plan
- Single byte, D=2, `spi_data`=8'hA5, `dc_in`=0:
  - MOSI sampled at the 8 SCLK rising edges reads 1,0,1,0,0,1,0,1.
  - `send_done` is high only in cycle 35.
  - `oled_cs_n` is low for cycles 1..34.
  - `oled_dc`=0 throughout.
- Back-to-back: a client holds `spi_send` high and changes data to 8'h3C with `dc_in`=1 on `send_done`:
  - The second accept occurs at cycle 36; `oled_dc` goes to 1 at cycle 37.
  - The second `send_done` occurs at cycle 71.
  - Exactly two bytes are framed.
- Request dropped at cycle 5 and data changed at cycle 3 (D=2, 8'hFF):
  - The full 8'hFF is transmitted.
  - `send_done` is still at cycle 35.
- Reset asserted at cycle 12 for one cycle:
  - `oled_cs_n`=1 and `oled_sclk`=0 immediately.
  - No `send_done` pulse.
  - A new request afterwards completes normally 17D+1 cycles after its accept edge.
- D=1 with `OLED_SPI_CS_GAP_EN` defined, 8'h01:
  - `send_done` at cycle 19.
  - `oled_cs_n` is high in cycle 18.
  - Only the last SCLK rising edge sees MOSI=1.
- Full-screen clear pattern, 1024×(3 command + 1 data) bytes at D=4:
  - The receiving SPI slave model checks the byte count, D/C per byte, and that no byte is duplicated or lost.

Source files
------------

// File: rtl/oled_spi_master.sv
// Byte-wide SPI mode-0 transmitter for an SSD1306 OLED panel with CS framing.
// Define OLED_SPI_CS_GAP_EN to add a CS-high gap state before send_done.
module oled_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_send,
  input  logic [7:0] spi_data,
  input  logic       dc_in,
  output logic       send_done,
  output logic       busy,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_cs_n,
  output logic       oled_dc
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
`ifdef OLED_SPI_CS_GAP_EN
  localparam logic [2:0] GAP   = 3'd4;
`endif
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    sh_q, sh_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          csn_q, csn_d;
  logic          dc_q, dc_d;
  logic          div_hit;

  assign div_hit = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    done_d  = done_q;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    dc_d    = dc_q;
    unique case (state_q)
      IDLE: begin
        if (spi_send) begin
          sh_d    = spi_data[6:0];
          mosi_d  = spi_data[7];
          dc_d    = dc_in;
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_hit) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      SHIFT: begin
        if (div_hit) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Falling edge: last bit stays on MOSI through HOLD
          if (sclk_q) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = HOLD;
            end else begin
              mosi_d = sh_q[6];
              sh_d   = {sh_q[5:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HOLD: begin
        if (div_hit) begin
          div_d = '0;
          csn_d = 1'b1;
`ifdef OLED_SPI_CS_GAP_EN
          state_d = GAP;
`else
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end else begin
          div_d = div_q + DW'(1);
        end
      end
`ifdef OLED_SPI_CS_GAP_EN
      GAP: begin
        if (div_hit) begin
          div_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
`endif
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        csn_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      dc_q    <= dc_d;
    end
  end

  assign send_done = done_q;
  assign busy      = busy_q;
  assign oled_sclk = sclk_q;
  assign oled_mosi = mosi_q;
  assign oled_cs_n = csn_q;
  assign oled_dc   = dc_q;

endmodule

// File: tb/tb_oled_spi_master.sv
// Self-checking bench for oled_spi_master: directed cases plus a random
// command/data stream checked by an SPI slave model and timing arithmetic.
module tb_oled_spi_master;

  localparam int D = 2;
`ifdef OLED_SPI_CS_GAP_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int TD  = 17 * D + 1 + G * D;
  localparam int TD1 = 17 + 1 + G;
  localparam int N   = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       send, dc, done, busy, sclk, mosi, csn, odc;
  logic [7:0] data;
  logic       send1, dc1, done1, busy1, sclk1, mosi1, csn1, odc1;
  logic [7:0] data1;

  oled_spi_master #(.CLK_DIV(D)) u_dut (
    .clk(clk), .reset(reset), .spi_send(send), .spi_data(data),
    .dc_in(dc), .send_done(done), .busy(busy), .oled_sclk(sclk),
    .oled_mosi(mosi), .oled_cs_n(csn), .oled_dc(odc)
  );

  oled_spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .spi_send(send1), .spi_data(data1),
    .dc_in(dc1), .send_done(done1), .busy(busy1), .oled_sclk(sclk1),
    .oled_mosi(mosi1), .oled_cs_n(csn1), .oled_dc(odc1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errs = 0;
  int checks = 0;
  int t0;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiving panel: sample MOSI on SCLK rising edges while selected
  int         sb_n = 0;
  int         partials = 0;
  logic [7:0] sb_sh;
  logic       sb_dc;
  logic [8:0] rx_q[$];
  int         done_q[$];

  always @(posedge sclk) begin
    if (!csn) begin
      if (sb_n == 0) sb_dc = odc;
      sb_sh = {sb_sh[6:0], mosi};
      sb_n++;
    end
  end

  always @(posedge csn) begin
    if (sb_n == 8) rx_q.push_back({sb_dc, sb_sh});
    else if (sb_n != 0) partials++;
    sb_n = 0;
  end

  always @(negedge clk) if (done) done_q.push_back(cyc);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rx(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    got = (rx_q.size() != 0) ? rx_q.pop_front() : 9'bx;
    chk(tag, 32'(got), 32'(exp));
  endtask

  task automatic chk_done(input string tag, input int exp);
    int got;
    got = (done_q.size() != 0) ? done_q.pop_front() - t0 : -1;
    chk(tag, got, exp);
  endtask

  function automatic logic sclk_exp(input int n, input int d);
    if (n < d + 1 || n > 16 * d) return 1'b0;
    return ((n - d - 1) / d) % 2 == 0;
  endfunction

  task automatic start(input logic [7:0] b, input logic d);
    @(posedge clk);
    #1;
    data = b;
    dc   = d;
    send = 1'b1;
    t0   = cyc;
  endtask

  task automatic clear_q();
    rx_q.delete();
    done_q.delete();
    partials = 0;
  endtask

  logic [8:0] exp_q[$];
  int         gap_q[$];

  initial begin
    int ndone, wait_n, budget, k, prev;
    logic [7:0] b, b1;
    logic       bd;

    reset = 1'b1;
    send = 0; data = 0; dc = 0;
    send1 = 0; data1 = 0; dc1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_csn", csn, 1'b1);
    chk("rst_dc", odc, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_q();

    // Single byte A5, full per-cycle timing
    start(8'hA5, 1'b0);
    for (int n = 0; n <= TD + 1; n++) begin
      @(negedge clk);
      chk("t1_csn", csn, !(n >= 1 && n <= 17 * D));
      chk("t1_done", done, n == TD);
      chk("t1_busy", busy, n >= 1 && n <= TD);
      chk("t1_sclk", sclk, sclk_exp(n, D));
      chk("t1_dc", odc, 1'b0);
      if (done) send = 1'b0;
    end
    chk("t1_cnt", rx_q.size(), 1);
    chk_rx("t1_byte", {1'b0, 8'hA5});
    chk_done("t1_tdone", TD);

    // Back-to-back with data change on send_done
    clear_q();
    b = 8'($urandom);
    start(b, 1'b0);
    ndone = 0;
    for (int n = 0; n <= 2 * TD + 4; n++) begin
      @(negedge clk);
      if (n == TD + 1) chk("t2_dc_old", odc, 1'b0);
      if (n == TD + 2) chk("t2_dc_new", odc, 1'b1);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          data = 8'h3C;
          dc   = 1'b1;
        end else begin
          send = 1'b0;
        end
      end
    end
    chk("t2_cnt", rx_q.size(), 2);
    chk_rx("t2_b0", {1'b0, b});
    chk_rx("t2_b1", {1'b1, 8'h3C});
    chk_done("t2_d0", TD);
    chk_done("t2_d1", 2 * TD + 1);

    // Request dropped and inputs changed mid-byte
    clear_q();
    start(8'hFF, 1'b0);
    for (int n = 0; n <= TD + 3; n++) begin
      @(negedge clk);
      if (n == 3) begin
        data = 8'h00;
        dc   = 1'b1;
      end
      if (n == 5) send = 1'b0;
    end
    chk("t3_cnt", rx_q.size(), 1);
    chk_rx("t3_byte", {1'b0, 8'hFF});
    chk_done("t3_tdone", TD);
    chk("t3_dc", odc, 1'b0);

    // Asynchronous reset mid-byte
    clear_q();
    start(8'($urandom), 1'b1);
    for (int n = 0; n < 12; n++) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t4_csn", csn, 1'b1);
    chk("t4_sclk", sclk, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_dc", odc, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send  = 1'b0;
    repeat (TD + 4) @(negedge clk);
    chk("t4_nodone", done_q.size(), 0);
    chk("t4_norx", rx_q.size(), 0);
    chk("t4_partial", partials, 1);
    b = 8'($urandom);
    start(b, 1'b1);
    for (int n = 0; n <= TD + 1; n++) begin
      @(negedge clk);
      if (done) send = 1'b0;
    end
    chk_rx("t4_byte", {1'b1, b});
    chk_done("t4_tdone", TD);

    // CLK_DIV=1 instance, byte 01
    b1 = 8'h01;
    @(posedge clk);
    #1;
    data1 = b1;
    dc1   = 1'b1;
    send1 = 1'b1;
    t0    = cyc;
    for (int n = 0; n <= TD1 + 1; n++) begin
      @(negedge clk);
      chk("t5_csn", csn1, !(n >= 1 && n <= 17));
      chk("t5_done", done1, n == TD1);
      chk("t5_sclk", sclk1, sclk_exp(n, 1));
      if (sclk_exp(n, 1)) chk("t5_mosi", mosi1, b1[7 - (n - 2) / 2]);
      if (n >= 1) chk("t5_dc", odc1, 1'b1);
      if (done1) send1 = 1'b0;
    end

    // Clear-screen style stream: 3 commands then 1 data byte, random gaps
    clear_q();
    exp_q.delete();
    gap_q.delete();
    ndone  = 0;
    wait_n = 0;
    k      = 0;
    budget = N * (TD + 8) + 100;
    start(8'($urandom), 1'b0);
    exp_q.push_back({dc, data});
    k = 1;
    while (ndone < N && budget > 0) begin
      @(negedge clk);
      budget--;
      if (done) begin
        ndone++;
        if (k < N) begin
          if ($urandom_range(0, 1) == 1) begin
            bd   = (k % 4) == 3;
            data = 8'($urandom);
            dc   = bd;
            exp_q.push_back({bd, data});
            gap_q.push_back(0);
            k++;
          end else begin
            send   = 1'b0;
            wait_n = $urandom_range(1, 3);
            gap_q.push_back(wait_n - 1);
          end
        end else begin
          send = 1'b0;
        end
      end else if (wait_n > 0) begin
        wait_n--;
        if (wait_n == 0) begin
          bd   = (k % 4) == 3;
          data = 8'($urandom);
          dc   = bd;
          send = 1'b1;
          exp_q.push_back({bd, data});
          k++;
        end
      end
    end
    repeat (4) @(negedge clk);
    chk("t6_ndone", ndone, N);
    chk("t6_rxcnt", rx_q.size(), N);
    while (exp_q.size() != 0) chk_rx("t6_byte", exp_q.pop_front());
    prev = (done_q.size() != 0) ? done_q.pop_front() : 0;
    while (done_q.size() != 0 && gap_q.size() != 0) begin
      k = done_q.pop_front();
      chk("t6_spacing", k - prev, TD + 1 + gap_q.pop_front());
      prev = k;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
